server_port_arbiter: RTL and testbench

//  Shares one server message port among N_CLIENTS requesters. Each client holds one tx message in a skid register;
//  a round-robin arbiter forwards held messages to the server. Server responses are routed back by head.dstid.
//  Per-client outstanding counters cap in-flight requests. Sits between client engines and a single server.

---
 rtl/server_port_arbiter_if.sv | 29 ++
 rtl/server_port_arbiter.sv | 131 +++++++++++++
 tb/tb_server_port_arbiter.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/server_port_arbiter_if.sv
// rtl/server_port_arbiter_if.sv - client/server message port bundle for the server port arbiter
interface server_port_arbiter_if #(
  parameter int N_CLIENTS = 4,
  parameter int MSG_W     = 704
);
  logic [N_CLIENTS*MSG_W-1:0] clt_tx_msg;
  logic [N_CLIENTS-1:0]       clt_tx;
  logic [N_CLIENTS-1:0]       clt_tx_full;
  logic [MSG_W-1:0]           srv_tx_msg;
  logic                       srv_tx;
  logic                       srv_tx_full;
  logic [MSG_W-1:0]           srv_rx_msg;
  logic                       srv_rx_empty;
  logic                       srv_rx_pop;
  logic [MSG_W-1:0]           clt_rx_msg;
  logic [N_CLIENTS-1:0]       clt_rx_empty;
  logic [N_CLIENTS-1:0]       clt_rx_pop;
  logic [15:0]                drop_count;

  modport slave (
    input  clt_tx_msg, clt_tx, srv_tx_full, srv_rx_msg, srv_rx_empty, clt_rx_pop,
    output clt_tx_full, srv_tx_msg, srv_tx, srv_rx_pop, clt_rx_msg, clt_rx_empty, drop_count
  );

  modport master (
    output clt_tx_msg, clt_tx, srv_tx_full, srv_rx_msg, srv_rx_empty, clt_rx_pop,
    input  clt_tx_full, srv_tx_msg, srv_tx, srv_rx_pop, clt_rx_msg, clt_rx_empty, drop_count
  );
endinterface

// File: rtl/server_port_arbiter.sv
// rtl/server_port_arbiter.sv - round-robin sharing of one server message port among N clients
module server_port_arbiter #(
  parameter int N_CLIENTS       = 4,
  parameter int SDARG_BITS      = 32,
  parameter int DATA_BITS       = 512,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  server_port_arbiter_if.slave bus
);
  localparam int MSG_W   = DATA_BITS + 6*SDARG_BITS;
  localparam int CIDX_W  = $clog2(N_CLIENTS);
  localparam int OCNT_W  = $clog2(MAX_OUTSTANDING+1);
  localparam int DST_LSB = 4*SDARG_BITS;

  logic [MSG_W-1:0]      hold_q [N_CLIENTS];
  logic [MSG_W-1:0]      hold_d [N_CLIENTS];
  logic [N_CLIENTS-1:0]  hold_valid_q, hold_valid_d;
  logic [OCNT_W-1:0]     ocnt_q [N_CLIENTS];
  logic [OCNT_W-1:0]     ocnt_d [N_CLIENTS];
  logic [CIDX_W-1:0]     rr_q, rr_d;
  logic                  srv_tx_q, srv_tx_d;
  logic [MSG_W-1:0]      srv_tx_msg_q, srv_tx_msg_d;
  logic [15:0]           drop_q, drop_d;

  logic [N_CLIENTS-1:0]  elig;
  logic                  gnt_valid;
  logic [CIDX_W-1:0]     gnt_idx;
  logic [SDARG_BITS-1:0] rx_dst;
  logic                  rx_valid;
  logic [CIDX_W-1:0]     rx_idx;
  logic                  rx_deliver;
  logic                  rx_drop;
  logic [N_CLIENTS-1:0]  rx_empty;

  always_comb begin
    for (int i = 0; i < N_CLIENTS; i++) begin
      elig[i] = hold_valid_q[i] && (ocnt_q[i] < OCNT_W'(MAX_OUTSTANDING));
    end
  end

  // Scan from the far end back toward rr_q so the last hit is the first eligible in rr order.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    if (!bus.srv_tx_full) begin
      for (int k = N_CLIENTS-1; k >= 0; k--) begin
        if (elig[CIDX_W'((int'(rr_q) + k) % N_CLIENTS)]) begin
          gnt_valid = 1'b1;
          gnt_idx   = CIDX_W'((int'(rr_q) + k) % N_CLIENTS);
        end
      end
    end
  end

  assign rx_dst     = bus.srv_rx_msg[DST_LSB +: SDARG_BITS];
  assign rx_valid   = (rx_dst < SDARG_BITS'(N_CLIENTS));
  assign rx_idx     = rx_dst[CIDX_W-1:0];
  assign rx_deliver = !bus.srv_rx_empty && rx_valid && bus.clt_rx_pop[rx_idx];
  assign rx_drop    = !bus.srv_rx_empty && !rx_valid;

  always_comb begin
    for (int i = 0; i < N_CLIENTS; i++) begin
      rx_empty[i] = bus.srv_rx_empty || !rx_valid || (rx_idx != CIDX_W'(i));
    end
  end

  always_comb begin
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    ocnt_d       = ocnt_q;
    rr_d         = rr_q;
    srv_tx_d     = gnt_valid;
    srv_tx_msg_d = srv_tx_msg_q;
    drop_d       = drop_q;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (bus.clt_tx[i] && !hold_valid_q[i]) begin
        hold_d[i]       = bus.clt_tx_msg[i*MSG_W +: MSG_W];
        hold_valid_d[i] = 1'b1;
      end
    end
    if (gnt_valid) begin
      hold_valid_d[gnt_idx] = 1'b0;
      srv_tx_msg_d          = hold_q[gnt_idx];
      rr_d = (gnt_idx == CIDX_W'(N_CLIENTS-1)) ? '0 : gnt_idx + CIDX_W'(1);
    end
    // A grant and a delivered pop to the same client cancel; unsolicited pops floor at zero.
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (gnt_valid && gnt_idx == CIDX_W'(i) && !(rx_deliver && rx_idx == CIDX_W'(i))) begin
        ocnt_d[i] = ocnt_q[i] + OCNT_W'(1);
      end else if (rx_deliver && rx_idx == CIDX_W'(i) && !(gnt_valid && gnt_idx == CIDX_W'(i))
                   && ocnt_q[i] != '0) begin
        ocnt_d[i] = ocnt_q[i] - OCNT_W'(1);
      end
    end
    if (rx_drop && drop_q != 16'hFFFF) begin
      drop_d = drop_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_valid_q <= '0;
      for (int i = 0; i < N_CLIENTS; i++) ocnt_q[i] <= '0;
      rr_q         <= '0;
      srv_tx_q     <= 1'b0;
      srv_tx_msg_q <= '0;
      drop_q       <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      ocnt_q       <= ocnt_d;
      rr_q         <= rr_d;
      srv_tx_q     <= srv_tx_d;
      srv_tx_msg_q <= srv_tx_msg_d;
      drop_q       <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    hold_q <= hold_d;
  end

  assign bus.clt_tx_full  = hold_valid_q;
  assign bus.srv_tx       = srv_tx_q;
  assign bus.srv_tx_msg   = srv_tx_msg_q;
  assign bus.srv_rx_pop   = rx_deliver || rx_drop;
  assign bus.clt_rx_msg   = bus.srv_rx_msg;
  assign bus.clt_rx_empty = rx_empty;
  assign bus.drop_count   = drop_q;
endmodule

// File: tb/tb_server_port_arbiter.sv
// tb/tb_server_port_arbiter.sv - directed bench with a behavioural reference model for server_port_arbiter
module tb_server_port_arbiter;
  localparam int N     = 4;
  localparam int S     = 32;
  localparam int DB    = 64;
  localparam int MAXO  = 2;
  localparam int MSG_W = DB + 6*S;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   chk_en = 1'b0;

  server_port_arbiter_if #(.N_CLIENTS(N), .MSG_W(MSG_W)) bus ();

  server_port_arbiter #(
    .N_CLIENTS(N), .SDARG_BITS(S), .DATA_BITS(DB), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference state: held messages, outstanding counts, rr position, server-side outputs.
  logic [N-1:0]     m_hv;
  logic [MSG_W-1:0] m_hold [N];
  int               m_ocnt [N];
  int               m_rr;
  logic             m_srv_tx;
  logic [MSG_W-1:0] m_srv_msg;
  int               m_drop;

  task automatic check(input string nm, input logic [MSG_W-1:0] act, input logic [MSG_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [MSG_W-1:0] mk(input int src, input int dst, input int tag);
    logic [MSG_W-1:0] m;
    m = '0;
    m[5*S +: S]  = src;
    m[4*S +: S]  = dst;
    m[3*S +: S]  = tag;
    m[6*S +: DB] = {tag, ~tag};
    return m;
  endfunction

  task automatic model_step();
    int g;
    logic [S-1:0] d;
    g = -1;
    if (!rst_n) begin
      m_hv = '0;
      for (int i = 0; i < N; i++) m_ocnt[i] = 0;
      m_rr = 0; m_srv_tx = 1'b0; m_srv_msg = '0; m_drop = 0;
      return;
    end
    if (!bus.srv_tx_full) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && m_hv[(m_rr + k) % N] && m_ocnt[(m_rr + k) % N] < MAXO) g = (m_rr + k) % N;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (bus.clt_tx[i] && !m_hv[i]) begin
        m_hv[i] = 1'b1;
        m_hold[i] = bus.clt_tx_msg[i*MSG_W +: MSG_W];
      end
    end
    if (g >= 0) begin
      m_srv_tx = 1'b1; m_srv_msg = m_hold[g]; m_hv[g] = 1'b0;
      m_rr = (g + 1) % N; m_ocnt[g] = m_ocnt[g] + 1;
    end else begin
      m_srv_tx = 1'b0;
    end
    d = bus.srv_rx_msg[4*S +: S];
    if (!bus.srv_rx_empty && d < N && bus.clt_rx_pop[d] && m_ocnt[d] > 0) m_ocnt[d] = m_ocnt[d] - 1;
    if (!bus.srv_rx_empty && d >= N && m_drop < 65535) m_drop = m_drop + 1;
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    logic [S-1:0] d;
    logic [N-1:0] ee;
    logic         ep;
    if (chk_en) begin
      d  = bus.srv_rx_msg[4*S +: S];
      ee = '1;
      if (!bus.srv_rx_empty && d < N) ee[d] = 1'b0;
      ep = !bus.srv_rx_empty && ((d < N) ? bus.clt_rx_pop[d] : 1'b1);
      check("m_clt_tx_full", bus.clt_tx_full, m_hv);
      check("m_srv_tx", bus.srv_tx, m_srv_tx);
      check("m_srv_tx_msg", bus.srv_tx_msg, m_srv_msg);
      check("m_drop_count", bus.drop_count, m_drop);
      check("m_clt_rx_empty", bus.clt_rx_empty, ee);
      check("m_srv_rx_pop", bus.srv_rx_pop, ep);
      check("m_clt_rx_msg", bus.clt_rx_msg, bus.srv_rx_msg);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.clt_tx = '0; bus.srv_tx_full = 1'b0; bus.srv_rx_empty = 1'b1; bus.clt_rx_pop = '0;
    tick();
    rst_n = 1'b1;
    check("rst_full", bus.clt_tx_full, 0);
    check("rst_srv_tx", bus.srv_tx, 0);
    check("rst_srv_msg", bus.srv_tx_msg, 0);
    check("rst_drop", bus.drop_count, 0);
  endtask

  task automatic push(input int i, input logic [MSG_W-1:0] m);
    bus.clt_tx_msg[i*MSG_W +: MSG_W] = m;
    bus.clt_tx[i] = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.clt_tx_msg = '0; bus.clt_tx = '0; bus.srv_tx_full = 1'b0;
    bus.srv_rx_msg = '0; bus.srv_rx_empty = 1'b1; bus.clt_rx_pop = '0;
    tick(); tick();
    chk_en = 1'b1;

    // single push latency
    do_reset();
    push(2, mk(2, 9, 'h11));
    tick(); bus.clt_tx = '0;
    check("t1_full_c1", bus.clt_tx_full, 4'b0100);
    check("t1_srvtx_c1", bus.srv_tx, 0);
    tick();
    check("t1_srvtx_c2", bus.srv_tx, 1);
    check("t1_msg_c2", bus.srv_tx_msg, mk(2, 9, 'h11));
    check("t1_full_c2", bus.clt_tx_full, 0);
    tick();
    check("t1_srvtx_c3", bus.srv_tx, 0);
    check("t1_msg_hold_c3", bus.srv_tx_msg, mk(2, 9, 'h11));

    // all clients, two rounds of rr
    do_reset();
    for (int i = 0; i < N; i++) push(i, mk(i, 0, 'h20 + i));
    tick(); bus.clt_tx = '0;
    check("t2_srvtx_c1", bus.srv_tx, 0);
    for (int k = 0; k < N; k++) begin
      tick();
      check("t2_r1_srvtx", bus.srv_tx, 1);
      check("t2_r1_src", bus.srv_tx_msg[5*S +: S], k);
    end
    for (int i = 0; i < N; i++) push(i, mk(i, 0, 'h30 + i));
    tick(); bus.clt_tx = '0;
    check("t2_srvtx_c6", bus.srv_tx, 0);
    for (int k = 0; k < N; k++) begin
      tick();
      check("t2_r2_srvtx", bus.srv_tx, 1);
      check("t2_r2_msg", bus.srv_tx_msg, mk(k, 0, 'h30 + k));
    end

    // server backpressure
    do_reset();
    push(1, mk(1, 0, 'h40));
    tick(); bus.clt_tx = '0; bus.srv_tx_full = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      check("t3_srvtx_blocked", bus.srv_tx, 0);
      check("t3_full1_blocked", bus.clt_tx_full[1], 1);
      tick();
    end
    bus.srv_tx_full = 1'b0;
    check("t3_srvtx_c6", bus.srv_tx, 0);
    check("t3_full1_c6", bus.clt_tx_full[1], 1);
    tick();
    check("t3_srvtx_c7", bus.srv_tx, 1);
    check("t3_full1_c7", bus.clt_tx_full[1], 0);
    check("t3_msg_c7", bus.srv_tx_msg, mk(1, 0, 'h40));

    // outstanding cap
    do_reset();
    push(1, mk(1, 0, 'h51));
    tick(); bus.clt_tx = '0;
    tick();
    check("t4_first", bus.srv_tx_msg, mk(1, 0, 'h51));
    push(1, mk(1, 0, 'h52));
    tick(); bus.clt_tx = '0;
    tick();
    check("t4_second_tx", bus.srv_tx, 1);
    check("t4_second", bus.srv_tx_msg, mk(1, 0, 'h52));
    push(1, mk(1, 0, 'h53));
    tick(); bus.clt_tx = '0;
    for (int c = 5; c <= 8; c++) begin
      check("t4_capped", bus.srv_tx, 0);
      if (c < 8) tick();
    end
    bus.srv_rx_msg = mk(0, 1, 'h5f); bus.srv_rx_empty = 1'b0; bus.clt_rx_pop = 4'b0010;
    #1;
    check("t4_rx_pop", bus.srv_rx_pop, 1);
    check("t4_rx_empty", bus.clt_rx_empty, 4'b1101);
    tick(); bus.srv_rx_empty = 1'b1; bus.clt_rx_pop = '0;
    check("t4_srvtx_c9", bus.srv_tx, 0);
    tick();
    check("t4_third_tx", bus.srv_tx, 1);
    check("t4_third", bus.srv_tx_msg, mk(1, 0, 'h53));

    // response routing and drops
    bus.srv_rx_msg = mk(0, 7, 'h60); bus.srv_rx_empty = 1'b0; bus.clt_rx_pop = '0;
    #1;
    check("t5_bad_pop", bus.srv_rx_pop, 1);
    check("t5_bad_empty", bus.clt_rx_empty, 4'hF);
    check("t5_drop0", bus.drop_count, 0);
    tick();
    check("t5_drop1", bus.drop_count, 1);
    bus.srv_rx_msg = mk(0, 3, 'h61);
    #1;
    check("t5_d3_empty", bus.clt_rx_empty, 4'b0111);
    check("t5_d3_nopop", bus.srv_rx_pop, 0);
    check("t5_d3_msg", bus.clt_rx_msg, mk(0, 3, 'h61));
    bus.clt_rx_pop = 4'b0001;
    #1;
    check("t5_wrong_client", bus.srv_rx_pop, 0);
    bus.clt_rx_pop = 4'b1000;
    #1;
    check("t5_right_client", bus.srv_rx_pop, 1);
    tick(); bus.srv_rx_empty = 1'b1; bus.clt_rx_pop = '0;
    check("t5_drop_stays", bus.drop_count, 1);

    // mid-operation reset
    do_reset();
    push(1, mk(1, 0, 'h71));
    tick(); bus.clt_tx = '0;
    tick();
    push(1, mk(1, 0, 'h72));
    tick(); bus.clt_tx = '0;
    tick();
    bus.srv_tx_full = 1'b1;
    push(0, mk(0, 0, 'h70)); push(2, mk(2, 0, 'h72)); push(3, mk(3, 0, 'h73));
    tick(); bus.clt_tx = '0;
    check("t6_full_pre", bus.clt_tx_full, 4'b1101);
    check("t6_srvtx_pre", bus.srv_tx, 0);
    rst_n = 1'b0;
    tick(); rst_n = 1'b1; bus.srv_tx_full = 1'b0;
    check("t6_full_post", bus.clt_tx_full, 0);
    check("t6_srvtx_post", bus.srv_tx, 0);
    push(1, mk(1, 0, 'h81)); push(3, mk(3, 0, 'h83));
    tick(); bus.clt_tx = '0;
    check("t6_full_c7", bus.clt_tx_full, 4'b1010);
    tick();
    check("t6_first_tx", bus.srv_tx, 1);
    check("t6_first", bus.srv_tx_msg, mk(1, 0, 'h81));
    tick();
    check("t6_second", bus.srv_tx_msg, mk(3, 0, 'h83));
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
